// File: rtl/axis_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : axis_uart_tx
// Purpose  : AXI-Stream slave to UART transmitter (start, LSB-first data,
//            optional parity, 1 or 2 stop bits). Optional parity via macro
//            AXIS_UART_TX_PARITY_EN (adds parameter PARITY_ODD).
// Revision : 1.0 - initial release
// ============================================================================

package axis_uart_pkg_prm;
  localparam int AXI_DATA_WIDTH = 8;
endpackage

module axis_uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int STOP_BITS = 1
`ifdef AXIS_UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic [axis_uart_pkg_prm::AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  output logic                                        uart_tx,
  output logic                                        tx_busy
);

  localparam int DW           = axis_uart_pkg_prm::AXI_DATA_WIDTH;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_MAX      = (DW > 2) ? DW : 2;
  localparam int IDX_W        = $clog2(IDX_MAX);

  generate
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("axis_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("axis_uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef AXIS_UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DW-1:0]     r_shift;
  logic [DW-1:0]     w_shift_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              r_busy;
  logic              w_bit_end;
  logic              w_accept;
`ifdef AXIS_UART_TX_PARITY_EN
  logic              r_par;
  logic              w_par_nxt;
`endif

  assign s_axis_tready = (r_state == S_IDLE) && !areset;
  assign uart_tx       = r_tx;
  assign tx_busy       = r_busy;

  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_accept  = s_axis_tvalid && s_axis_tready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_bit_end ? '0 : r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
`ifdef AXIS_UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      S_IDLE: begin
        // Counter is held at zero so START lasts exactly one full bit period.
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_START;
          w_shift_nxt = s_axis_tdata;
`ifdef AXIS_UART_TX_PARITY_EN
          w_par_nxt   = (^s_axis_tdata) ^ PARITY_ODD[0];
`endif
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == IDX_W'(DW - 1)) begin
            w_idx_nxt = '0;
`ifdef AXIS_UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
`ifdef AXIS_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // The bit index is reused to count stop bits.
        if (w_bit_end) begin
          if (r_idx == IDX_W'(STOP_BITS - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase

    // Line level follows the next state so the flop output lines up with it.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef AXIS_UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
`ifdef AXIS_UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_uart_tx
// Purpose  : Directed self-checking bench for axis_uart_tx (1 and 2 stop bits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_uart_tx;

  localparam int CPB = 10;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata_a = 8'h00;
  logic [7:0] tdata_b = 8'h00;
  logic       tvalid_a = 1'b0;
  logic       tvalid_b = 1'b0;
  logic       rdy_a, rdy_b, tx_a, tx_b, busy_a, busy_b;

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int first_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_uart_tx #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .STOP_BITS(1)
`ifdef AXIS_UART_TX_PARITY_EN
    , .PARITY_ODD(0)
`endif
  ) dut_a (
    .aclk(clk), .areset(rst), .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid_a),
    .s_axis_tready(rdy_a), .uart_tx(tx_a), .tx_busy(busy_a)
  );

  axis_uart_tx #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .STOP_BITS(2)
`ifdef AXIS_UART_TX_PARITY_EN
    , .PARITY_ODD(1)
`endif
  ) dut_b (
    .aclk(clk), .areset(rst), .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b),
    .s_axis_tready(rdy_b), .uart_tx(tx_b), .tx_busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the accepting edge.
  function automatic logic exp_bit(input int k, input logic [7:0] d, input logic podd);
    int idx;
    idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if ((P == 1) && (idx == 9)) return (^d) ^ podd;
    return 1'b1;
  endfunction

  task automatic accept(input bit sel, input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    if (sel) begin tdata_b = d; tvalid_b = 1'b1; end
    else     begin tdata_a = d; tvalid_a = 1'b1; end
    while (!(sel ? rdy_b : rdy_a) && (n < 400)) begin
      tick();
      n++;
    end
    check("accept_wait", (n < 400), 1);
    tick();
    acc_cyc = cyc;
    if (!hold) begin
      if (sel) tvalid_b = 1'b0;
      else     tvalid_a = 1'b0;
    end
  endtask

  task automatic check_frame(input bit sel, input logic [7:0] d, input int nstop,
                             input logic podd, input string tag);
    int len;
    len = (1 + 8 + P + nstop) * CPB;
    for (int k = 0; k < len; k++) begin
      check({tag, "_tx"},      sel ? tx_b   : tx_a,   exp_bit(k, d, podd));
      check({tag, "_busy"},    sel ? busy_b : busy_a, 1);
      check({tag, "_rdy_low"}, sel ? rdy_b  : rdy_a,  0);
      tick();
    end
    check({tag, "_busy_end"}, sel ? busy_b : busy_a, 0);
    check({tag, "_rdy_end"},  sel ? rdy_b  : rdy_a,  1);
    check({tag, "_tx_end"},   sel ? tx_b   : tx_a,   1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset behaviour
    rst = 1'b1;
    repeat (3) tick();
    check("rst_tx_a",   tx_a,   1);
    check("rst_busy_a", busy_a, 0);
    check("rst_rdy_a",  rdy_a,  0);
    check("rst_tx_b",   tx_b,   1);
    check("rst_rdy_b",  rdy_b,  0);
    rst = 1'b0;
    tick();
    check("rdy_after_rst_a", rdy_a, 1);
    check("rdy_after_rst_b", rdy_b, 1);

    // Idle with no valid
    repeat (20) tick();
    check("idle_tx",   tx_a,   1);
    check("idle_busy", busy_a, 0);
    check("idle_rdy",  rdy_a,  1);

    // Single 0x55 frame
    accept(0, 8'h55, 0);
    check_frame(0, 8'h55, 1, 1'b0, "f55");

    // Back-to-back 0xA3, 0x0F with tvalid held
    accept(0, 8'hA3, 1);
    first_acc = acc_cyc;
    check_frame(0, 8'hA3, 1, 1'b0, "fA3");
    accept(0, 8'h0F, 0);
    check("b2b_spacing", acc_cyc - first_acc, (1 + 8 + P + 1) * CPB + 1);
    check_frame(0, 8'h0F, 1, 1'b0, "f0F");

    // Two stop bits, 0xFF
    accept(1, 8'hFF, 0);
    check_frame(1, 8'hFF, 2, 1'b1, "fFF_2stop");

    // Reset mid-frame of 0x00, then a clean 0x81
    accept(0, 8'h00, 0);
    repeat (35) tick();
    check("mid_tx_low",  tx_a,   0);
    check("mid_busy",    busy_a, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy_comb", rdy_a, 0);
    tick();
    check("mid_rst_tx",   tx_a,   1);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_rdy",  rdy_a,  0);
    rst = 1'b0;
    tick();
    check("post_rst_rdy", rdy_a, 1);
    check("post_rst_tx",  tx_a,  1);
    accept(0, 8'h81, 0);
    check_frame(0, 8'h81, 1, 1'b0, "f81");

`ifdef AXIS_UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    accept(0, 8'h07, 0);
    repeat (90) tick();
    check("par_even_bit", tx_a, 1);
    repeat (20) tick();
    check("par_even_rdy", rdy_a, 1);
    accept(1, 8'h07, 0);
    repeat (90) tick();
    check("par_odd_bit", tx_b, 0);
    repeat (30) tick();
    check("par_odd_rdy", rdy_b, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_uart_tx.md
Name: axis_uart_tx

Overview:
- AXI-Stream slave to UART transmitter; serializes each accepted tdata word onto a single TX line.
- Sits directly downstream of the AXI-Stream producer and connects to the s_axis side of the stream interface.
- Data width comes from axis_uart_pkg_prm::AXI_DATA_WIDTH, default 8.
- Frame format: 1 start bit (0), AXI_DATA_WIDTH data bits sent LSB first, optional parity bit, STOP_BITS stop bits (1).

Parameters:
- CLK_FREQ, 50_000_000, aclk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2; any other value is an elaboration error.
- Derived constant CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division). CLKS_PER_BIT < 2 is an elaboration error.

Ports:
- aclk  in  1  Single clock; all logic on its rising edge.
- areset  in  1  Synchronous, active-high reset.
- s_axis_tdata  in  AXI_DATA_WIDTH  Byte or word to transmit.
- s_axis_tvalid  in  1  Upstream data valid.
- s_axis_tready  out  1  Block can accept a word.
- uart_tx  out  1  Serial line output, registered, idle high.
- tx_busy  out  1  High while a frame is on the line (any state other than IDLE).

Behaviour:
- Interface: one clock (aclk); reset areset is synchronous and active-high. The module also exposes a modport-compatible port set so it can bind to axis_if.s_axis.
- Reset:
  - State goes to IDLE; uart_tx = 1; tx_busy = 0; s_axis_tready = 0 while areset is high.
  - The baud counter, bit index and shift register clear to 0.
  - Reset asserted mid-frame aborts the frame. uart_tx is 1 on the first edge with areset high. The partial frame is not retried.
- s_axis_tready = (state == IDLE) && !areset. It is 1 on the first cycle after reset deasserts.
- Handshake:
  - A transfer occurs on an edge where tvalid && tready are both 1.
  - tdata is latched into the shift register; the state goes to START on the next cycle and tready drops.
  - With tvalid = 0 the block remains in IDLE indefinitely with uart_tx = 1.
  - Upstream must hold tdata and tvalid until tready; the block relies only on standard AXI-S rules.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Bit timing:
  - Baud counter runs 0 .. CLKS_PER_BIT-1. Each line bit is held exactly CLKS_PER_BIT cycles.
  - The state or bit advances on the cycle where counter == CLKS_PER_BIT-1; the counter then wraps to 0.
- Per-state rules:
  - START: uart_tx = 0.
  - DATA: uart_tx = shift[0]; shift right on each bit boundary. The bit index counts 0 .. AXI_DATA_WIDTH-1 and leaves DATA after the last bit.
  - STOP: uart_tx = 1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Latency:
  - uart_tx falls exactly 1 cycle after the accepting edge.
  - Frame length is (1 + AXI_DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 if parity is enabled, else 0.
  - The minimum start-to-start spacing for back-to-back words is frame length + 1 cycle (one IDLE acceptance cycle).
- tx_busy = (state != IDLE), registered with the state.
- uart_tx is driven from a flop, so the line never glitches.

Optional Feature:
- Macro: AXIS_UART_TX_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0) is added.
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Parity bit = ^tdata_latched XOR PARITY_ODD (even parity by default).
  - Frame length includes P = 1.
- When undefined: no PARITY state or logic is generated, P = 0, and the PARITY_ODD parameter does not exist.

Test Plan:
- Use CLK_FREQ=50_000_000, BAUD_RATE=5_000_000 (CLKS_PER_BIT=10), STOP_BITS=1 unless stated.
1. Reset release -> uart_tx=1, tx_busy=0, tready=0 during reset; tready=1 on the first cycle after areset falls.
2. Send 0x55 -> 1 cycle after handshake, uart_tx reads 0,1,0,1,0,1,0,1,0,1, each held 10 cycles. The sequence is start, LSB-first data, stop. tready returns to 1 at cycle 101 after the handshake.
3. Back-to-back 0xA3 then 0x0F with tvalid held high -> second handshake exactly 101 cycles after the first. Both frames decode correctly with no extra idle.
4. Set STOP_BITS=2 and send 0xFF -> start low for 10 cycles, then line high for 8*10 + 2*10 = 100 cycles. tx_busy stays high for 110 cycles total.
5. Assert areset at cycle 35 of a 0x00 frame -> uart_tx=1 on the next edge, tready=0 while in reset. A new 0x81 sent after release transmits a clean full frame.
6. With AXIS_UART_TX_PARITY_EN defined and PARITY_ODD=0, send 0x07 -> parity bit = 1 at cycles 91-100 after the handshake, then stop. With PARITY_ODD=1 the parity bit is 0. Frame is 110 cycles.
